// File: rtl/block_move_ctrl.sv
// -----------------------------------------------------------------------------
// block_move_ctrl
//
// Controls one sliding block. The block starts at column 0, is drawn through
// the plotter, and waits FRAMES_PER_STEP frame ticks. It is then erased, moved
// one column and redrawn. It bounces between 0 and X_MAX. A player drop
// freezes the block in place, with the block drawn (LOCKED).
//
// Ports
//   clk         single clock, all logic on posedge
//   reset       synchronous, active-high reset
//   start       level-sampled request to begin a new block (IDLE/LOCKED only)
//   drop        player request to stop the sliding block
//   frame_tick  one-cycle pulse from the frame delay counter
//   delay_en    enable for the frame delay counter (1 only while waiting)
//   plot_req    request to the plotter to draw/erase the block at block_x
//   plot_done   one-cycle completion pulse from the plotter
//   plot_erase  1 = background colour, 0 = block colour
//   block_x     current block column, always within 0..X_MAX
//   dir         0 = moving right, 1 = moving left
//   locked      the block has been dropped
// -----------------------------------------------------------------------------
module block_move_ctrl #(
    parameter int X_W             = 8,
    parameter int X_MAX           = 152,
    parameter int FRAMES_PER_STEP = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           drop,
    input  logic           frame_tick,
    output logic           delay_en,
    output logic           plot_req,
    input  logic           plot_done,
    output logic           plot_erase,
    output logic [X_W-1:0] block_x,
    output logic           dir,
    output logic           locked
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAW,
        S_WAIT,
        S_ERASE,
        S_STEP,
        S_LOCKED
    } state_t;

    typedef struct packed {
        logic plot_req;
        logic plot_erase;
        logic delay_en;
        logic locked;
    } flags_t;

    localparam logic [X_W-1:0] X_LAST     = X_W'(X_MAX);
    // Columns the block lands on after bouncing off each wall. With a
    // single-column track the block just stays at 0.
    localparam logic [X_W-1:0] X_BOUNCE_R = (X_MAX == 0) ? '0 : X_W'(X_MAX - 1);
    localparam logic [X_W-1:0] X_BOUNCE_L = (X_MAX == 0) ? '0 : X_W'(1);
    localparam logic [7:0]     FRAME_LAST = 8'(FRAMES_PER_STEP - 1);

    state_t      state;
    flags_t      flags;
    logic [7:0]  frame_cnt;
    logic        drop_pending;

    // Output flags are a pure function of a state. They are loaded into flops
    // together with that state, so the outputs are glitch-free registers.
    function automatic flags_t decode(input state_t s);
        flags_t f;
        f = '0;
        case (s)
            S_DRAW:   f.plot_req = 1'b1;
            S_ERASE:  begin
                f.plot_req   = 1'b1;
                f.plot_erase = 1'b1;
            end
            S_WAIT:   f.delay_en = 1'b1;
            S_LOCKED: f.locked   = 1'b1;
            default:  f = '0;
        endcase
        return f;
    endfunction

    assign {plot_req, plot_erase, delay_en, locked} = flags;

    // NOTE: reset is tested inside the clocked block, so it acts only at an
    // edge. It overrides every other input in that cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: all state updates in this block use non-blocking (<=)
            // assignments, so every branch sees the pre-edge values.
            state        <= S_IDLE;
            flags        <= '0;
            block_x      <= '0;
            dir          <= 1'b0;
            frame_cnt    <= '0;
            drop_pending <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_LOCKED: begin
                    if (start) begin
                        block_x      <= '0;
                        dir          <= 1'b0;
                        frame_cnt    <= '0;
                        drop_pending <= 1'b0;
                        state        <= S_DRAW;
                        flags        <= decode(S_DRAW);
                    end
                end

                S_DRAW: begin
                    if (drop) drop_pending <= 1'b1;
                    if (plot_done) begin
                        state <= S_WAIT;
                        flags <= decode(S_WAIT);
                    end
                end

                S_WAIT: begin
                    // A drop (pending or live) beats a frame tick in the
                    // same cycle. The block is left drawn and never erased.
                    if (drop_pending || drop) begin
                        state <= S_LOCKED;
                        flags <= decode(S_LOCKED);
                    end else if (frame_tick) begin
                        if (frame_cnt == FRAME_LAST) begin
                            frame_cnt <= '0;
                            state     <= S_ERASE;
                            flags     <= decode(S_ERASE);
                        end else begin
                            frame_cnt <= frame_cnt + 8'd1;
                        end
                    end
                end

                S_ERASE: begin
                    if (drop) drop_pending <= 1'b1;
                    if (plot_done) begin
                        state <= S_STEP;
                        flags <= decode(S_STEP);
                    end
                end

                S_STEP: begin
                    // A drop seen here is honoured in the next WAIT, after
                    // the block has been redrawn at its new column.
                    if (drop) drop_pending <= 1'b1;
                    if (!dir) begin
                        if (block_x < X_LAST) begin
                            block_x <= block_x + X_W'(1);
                        end else begin
                            dir     <= 1'b1;
                            block_x <= X_BOUNCE_R;
                        end
                    end else begin
                        if (block_x != '0) begin
                            block_x <= block_x - X_W'(1);
                        end else begin
                            dir     <= 1'b0;
                            block_x <= X_BOUNCE_L;
                        end
                    end
                    state <= S_DRAW;
                    flags <= decode(S_DRAW);
                end

                default: begin
                    state <= S_IDLE;
                    flags <= decode(S_IDLE);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_block_move_ctrl.sv
// -----------------------------------------------------------------------------
// tb_block_move_ctrl
//
// Directed scenarios followed by a randomized run. Every cycle the DUT
// outputs are compared against a behavioural model. The model tracks how many
// moves the block has made and derives the column and direction arithmetically
// from a triangle wave of period 2*X_MAX. A simple plotter answers each
// plot_req with plot_done after a fixed delay.
// -----------------------------------------------------------------------------
module tb_block_move_ctrl;

    localparam int X_W = 8;
    localparam int X_MAX = 3;
    localparam int FPS = 2;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           start = 1'b0;
    logic           drop = 1'b0;
    logic           frame_tick = 1'b0;
    logic           plot_done = 1'b0;
    logic           delay_en;
    logic           plot_req;
    logic           plot_erase;
    logic [X_W-1:0] block_x;
    logic           dir;
    logic           locked;

    logic stray_done = 1'b0;
    int   req_age = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    block_move_ctrl #(
        .X_W(X_W),
        .X_MAX(X_MAX),
        .FRAMES_PER_STEP(FPS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .drop(drop),
        .frame_tick(frame_tick),
        .delay_en(delay_en),
        .plot_req(plot_req),
        .plot_done(plot_done),
        .plot_erase(plot_erase),
        .block_x(block_x),
        .dir(dir),
        .locked(locked)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef enum {M_OFF, M_PAINT, M_COUNT, M_CLEAR, M_MOVE, M_HELD} mode_t;
    mode_t m_mode = M_OFF;
    int    m_steps = 0;
    int    m_frames = 0;
    bit    m_pend = 1'b0;

    task automatic model_step();
        if (reset) begin
            m_mode = M_OFF; m_steps = 0; m_frames = 0; m_pend = 1'b0;
        end else begin
            case (m_mode)
                M_OFF, M_HELD: if (start) begin
                    m_mode = M_PAINT; m_steps = 0; m_frames = 0; m_pend = 1'b0;
                end
                M_PAINT: begin
                    if (drop) m_pend = 1'b1;
                    if (plot_done) m_mode = M_COUNT;
                end
                M_COUNT: begin
                    if (m_pend || drop) m_mode = M_HELD;
                    else if (frame_tick) begin
                        m_frames++;
                        if (m_frames == FPS) begin
                            m_frames = 0;
                            m_mode = M_CLEAR;
                        end
                    end
                end
                M_CLEAR: begin
                    if (drop) m_pend = 1'b1;
                    if (plot_done) m_mode = M_MOVE;
                end
                M_MOVE: begin
                    if (drop) m_pend = 1'b1;
                    m_steps++;
                    m_mode = M_PAINT;
                end
                default: m_mode = M_OFF;
            endcase
        end
    endtask

    function automatic logic [31:0] exp_vec();
        int pos;
        int ex;
        logic ed;
        pos = m_steps % (2 * X_MAX);
        ex = (pos <= X_MAX) ? pos : 2 * X_MAX - pos;
        ed = (pos > X_MAX) || (pos == 0 && m_steps > 0);
        return {19'd0, (m_mode == M_PAINT || m_mode == M_CLEAR), (m_mode == M_CLEAR),
                (m_mode == M_COUNT), (m_mode == M_HELD), ed, 8'(ex)};
    endfunction

    function automatic logic [31:0] dut_vec();
        return {19'd0, plot_req, plot_erase, delay_en, locked, dir, block_x};
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    endtask

    // One clock cycle: the plotter decides plot_done, then the edge, then the
    // model advances on the same inputs and the outputs are compared.
    task automatic cycle();
        plot_done = stray_done;
        if (plot_req === 1'b1) begin
            if (req_age == 3) plot_done = 1'b1;
            req_age++;
        end else begin
            req_age = 0;
        end
        @(posedge clk);
        #1;
        model_step();
        start = 1'b0; drop = 1'b0; frame_tick = 1'b0;
        stray_done = 1'b0; plot_done = 1'b0;
        check("cycle_model", dut_vec(), exp_vec());
    endtask

    task automatic wait_req(input logic level, input string tag);
        for (int i = 0; i < 20 && plot_req !== level; i++) cycle();
        check(tag, {31'd0, plot_req}, {31'd0, level});
    endtask

    task automatic two_ticks();
        frame_tick = 1'b1; cycle();
        cycle();
        frame_tick = 1'b1; cycle();
    endtask

    task automatic move_once();
        wait_req(1'b0, "move_draw_done");
        two_ticks();
        check("move_erase_start", {30'd0, plot_req, plot_erase}, 32'd3);
        wait_req(1'b0, "move_erase_done");
        wait_req(1'b1, "move_redraw");
        check("move_redraw_colour", {31'd0, plot_erase}, 32'd0);
    endtask

    logic [7:0] xs[8];
    logic       ds[8];
    int         exp_xs[8] = '{0, 1, 2, 3, 2, 1, 0, 1};
    bit         exp_ds[8] = '{0, 0, 0, 0, 1, 1, 1, 0};
    logic [7:0] saved_x;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        reset = 1'b1; cycle(); cycle();
        check("reset_outputs", dut_vec(), 32'd0);
        reset = 1'b0;

        // Start -> draw at column 0, then wait with the delay counter enabled
        start = 1'b1; cycle();
        check("start_draw", {22'd0, plot_req, plot_erase, block_x}, {22'd0, 1'b1, 1'b0, 8'd0});
        wait_req(1'b0, "first_draw_done");
        check("wait_after_draw", {30'd0, delay_en, plot_req}, 32'd2);

        // One tick alone does not erase; the second one does
        frame_tick = 1'b1; cycle();
        repeat (4) cycle();
        check("one_tick_no_erase", {30'd0, plot_req, delay_en}, 32'd1);
        frame_tick = 1'b1; cycle();
        check("erase_at_0", {22'd0, plot_req, plot_erase, block_x}, {22'd0, 2'b11, 8'd0});
        wait_req(1'b0, "erase_done");
        wait_req(1'b1, "redraw_start");
        check("draw_at_1", {22'd0, plot_req, plot_erase, block_x}, {22'd0, 2'b10, 8'd1});

        // Bounce sequence across the whole track
        reset = 1'b1; cycle(); reset = 1'b0;
        start = 1'b1; cycle();
        xs[0] = block_x; ds[0] = dir;
        for (int k = 1; k < 8; k++) begin
            move_once();
            xs[k] = block_x; ds[k] = dir;
        end
        for (int k = 0; k < 8; k++) begin
            check($sformatf("edge_x%0d", k), {24'd0, xs[k]}, exp_xs[k]);
            check($sformatf("edge_dir%0d", k), {31'd0, ds[k]}, {31'd0, exp_ds[k]});
        end

        // Drop coinciding with the second tick: lock without erasing
        saved_x = block_x;
        wait_req(1'b0, "pre_drop_draw_done");
        frame_tick = 1'b1; cycle();
        cycle();
        frame_tick = 1'b1; drop = 1'b1; cycle();
        check("drop_locks", {29'd0, locked, plot_req, delay_en}, 32'd4);
        check("drop_keeps_x", {24'd0, block_x}, {24'd0, saved_x});
        repeat (6) cycle();
        drop = 1'b1; cycle();
        check("locked_holds", {22'd0, locked, plot_req, block_x}, {22'd0, 2'b10, saved_x});

        // Drop during the erase at column 1: step, redraw at 2, then lock
        start = 1'b1; cycle();
        move_once();
        wait_req(1'b0, "x1_draw_done");
        two_ticks();
        check("erase_at_1", {22'd0, plot_req, plot_erase, block_x}, {22'd0, 2'b11, 8'd1});
        drop = 1'b1; cycle();
        wait_req(1'b0, "erase_drop_done");
        wait_req(1'b1, "redraw_after_drop");
        check("draw_at_2", {22'd0, plot_req, plot_erase, block_x}, {22'd0, 2'b10, 8'd2});
        wait_req(1'b0, "draw_2_done");
        cycle();
        check("locked_at_2", {23'd0, locked, block_x}, {23'd0, 1'b1, 8'd2});

        // Reset in the middle of a draw, then a stray plot_done
        start = 1'b1; cycle();
        check("restart_draw", {31'd0, plot_req}, 32'd1);
        cycle();
        reset = 1'b1; cycle(); reset = 1'b0;
        check("reset_mid_draw", dut_vec(), 32'd0);
        stray_done = 1'b1; cycle();
        check("stray_done_ignored", dut_vec(), 32'd0);
        cycle();
        check("still_idle", dut_vec(), 32'd0);

        // Randomized run against the model
        for (int n = 0; n < 3000; n++) begin
            reset      = ($urandom_range(0, 299) == 0);
            start      = ($urandom_range(0, 19) == 0);
            drop       = ($urandom_range(0, 59) == 0);
            frame_tick = ($urandom_range(0, 2) == 0);
            stray_done = (plot_req === 1'b0) && ($urandom_range(0, 9) == 0);
            cycle();
            reset = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
